bsg_decode_one_hot_buffered: RTL and testbench
==============================================

# bsg_decode_one_hot_buffered

Binary-index to one-hot decoder with a 2-entry elastic buffer and valid/ready handshakes on both sides. It converts a stream of `addr_i` indices into `width_p`-bit one-hot vectors, flags out-of-range indices and keeps a saturating error count. It sits in front of select/enable fanout logic and loops back against `bsg_encode_one_hot` in the platform benches.

## Interface
- `width_p`, default 8: one-hot output width; must be ≥1. Non-powers of two are allowed.
- `count_width_p`, default 8: width of the error counter.
- `addr_width_lp`, derived: `BSG_SAFE_CLOG2(width_p)`.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `reset_n_i`  in  1  reset; asynchronous assertion, active-low.
- `v_i`  in  1  input index valid.
- `addr_i`  in  addr_width_lp  binary index.
- `ready_o`  out  1  buffer can accept an entry; registered.
- `v_o`  out  1  head entry valid; registered.
- `data_o`  out  width_p  one-hot of the head entry; all zeros if the head is out of range or `v_o`=0.
- `err_o`  out  1  head entry was out of range (`addr_i` ≥ `width_p`); qualified by `v_o`.
- `yumi_i`  in  1  consumer takes the head entry; legal only when `v_o`=1.
- `err_count_o`  out  count_width_p  saturating count of accepted out-of-range entries.

## Operation
- Enqueue on `v_i & ready_o`. Dequeue on `v_o & yumi_i`.
- `yumi_i` asserted while `v_o`=0 is ignored and changes no state.
- Storage: 2 entries, each holding the precomputed one-hot and an error bit. Decoding happens on the input side, before storage.
- Decode: `data = (addr_i < width_p) ? (1 << addr_i) : '0`; `err = (addr_i >= width_p)`. For power-of-two `width_p`, `err` is constant 0.
- State machine tracks occupancy:
  - EMPTY: `v_o`=0, `ready_o`=1. Enqueue → ONE.
  - ONE: `v_o`=1, `ready_o`=1. Enqueue only → TWO. Dequeue only → EMPTY. Both at once → ONE, with the new entry becoming the head.
  - TWO: `v_o`=1, `ready_o`=0. Dequeue → ONE. No enqueue is possible because `ready_o`=0.
- `ready_o` depends only on registered state. There is no combinational path from `yumi_i` to `ready_o`, so in TWO a same-cycle dequeue does not free space for that cycle.
- Ordering is strict FIFO.
- `err_count_o` increments by 1 on each enqueue with `err`=1 and saturates at 2^count_width_p − 1. It never wraps and is cleared only by reset.
- Reset (`reset_n_i`=0, asynchronous) forces:
  - occupancy to EMPTY, so `v_o`=0 and `data_o`=0, `err_o`=0;
  - `err_count_o`=0;
  - `ready_o`=0.
- After reset release, `ready_o` rises on the first rising edge of `clk_i` (registered reset-done flag).
- Reset asserted mid-operation discards all buffered entries immediately. No partial handshake completes in that cycle.

## Timing
- Latency: an index enqueued at edge N appears on `v_o`/`data_o` after edge N when the buffer was EMPTY, or when it was ONE and dequeued in the same cycle. Otherwise it appears after the preceding entry is dequeued.
- Throughput: 1 entry/cycle sustained with `yumi_i` held high (stays in ONE).
- All outputs are registered. There are no combinational input→output paths.
- `data_o`/`err_o` are stable while `v_o`=1 and `yumi_i`=0.

## Test plan
- Reset: hold `reset_n_i`=0 with `v_i`=1. Required: `v_o`=0, `ready_o`=0, `err_count_o`=0. Release; after 1 edge `ready_o`=1.
- Streaming, `width_p`=8: send `addr_i`=0..7 back-to-back with `yumi_i`=1. Required: `data_o` = 0x01, 0x02, …, 0x80 on consecutive cycles, 1-cycle latency, `err_o`=0. Loop `data_o` into `bsg_encode_one_hot` and check it returns the same address.
- Backpressure: `yumi_i`=0, send 3, 5, 6. Required: 3 and 5 accepted, `ready_o`=0 after the second enqueue, 6 is held off. Then pulse `yumi_i` once. Required: `data_o` 0x08 → 0x20, then `ready_o`=1 and 6 is accepted.
- Out of range, `width_p`=6: send `addr_i`=5, 6, 7. Required: `data_o`=0x20, 0x00, 0x00; `err_o`=0, 1, 1; `err_count_o`=2.
- Saturation, `count_width_p`=2: send 5 out-of-range indices. Required: `err_count_o` reads 1, 2, 3, 3, 3.
- Mid-operation reset: fill to TWO, then assert `reset_n_i`=0 between edges. Required: `v_o`=0 immediately (asynchronous). After release, no stale entries are emitted.

Source files
------------

// File: rtl/bsg_decode_one_hot_buffered_if.sv
// rtl/bsg_decode_one_hot_buffered_if.sv - index-in / one-hot-out handshake bundle
interface bsg_decode_one_hot_buffered_if #(
   parameter int width_p       = 8,
   parameter int count_width_p = 8,
   parameter int addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1
);
   logic                     v_i;
   logic [addr_width_lp-1:0] addr_i;
   logic                     ready_o;
   logic                     v_o;
   logic [width_p-1:0]       data_o;
   logic                     err_o;
   logic                     yumi_i;
   logic [count_width_p-1:0] err_count_o;

   modport master (
      output v_i, addr_i, yumi_i,
      input  ready_o, v_o, data_o, err_o, err_count_o
   );

   modport slave (
      input  v_i, addr_i, yumi_i,
      output ready_o, v_o, data_o, err_o, err_count_o
   );
endinterface

// File: rtl/bsg_decode_one_hot_buffered.sv
// rtl/bsg_decode_one_hot_buffered.sv - binary to one-hot decoder with 2-entry elastic buffer
module bsg_decode_one_hot_buffered #(
   parameter int width_p       = 8,
   parameter int count_width_p = 8
) (
   input logic                          clk_i,
   input logic                          reset_n_i,
   bsg_decode_one_hot_buffered_if.slave bus
);
   localparam int addr_width_lp = (width_p > 1) ? $clog2(width_p) : 1;
   localparam logic [addr_width_lp:0] width_lim_lp = (addr_width_lp + 1)'(width_p);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

   state_e                   state;
   state_e                   state_next;
   logic                     ready_q;
   logic                     v_q;
   logic [width_p-1:0]       head_data;
   logic                     head_err;
   logic [width_p-1:0]       tail_data;
   logic                     tail_err;
   logic [count_width_p-1:0] err_count;
   logic [width_p-1:0]       dec_data;
   logic                     dec_err;
   logic                     enq;
   logic                     deq;

   // Decode before storage so the head register drives data_o directly.
   always_comb begin
      dec_data = '0;
      for (int i = 0; i < width_p; i++) begin
         if (bus.addr_i == addr_width_lp'(i)) dec_data[i] = 1'b1;
      end
   end

   generate
      if (width_p == (1 << addr_width_lp)) begin : g_pow2
         assign dec_err = 1'b0;
      end else begin : g_npow2
         assign dec_err = ({1'b0, bus.addr_i} >= width_lim_lp);
      end
   endgenerate

   assign enq = bus.v_i & ready_q;
   assign deq = v_q & bus.yumi_i;

   always_comb begin
      state_next = state;
      case (state)
         EMPTY: if (enq) state_next = ONE;
         ONE: begin
            if (enq && !deq)      state_next = TWO;
            else if (!enq && deq) state_next = EMPTY;
         end
         TWO: if (deq) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= EMPTY;
         v_q       <= 1'b0;
         ready_q   <= 1'b0;
         head_data <= '0;
         head_err  <= 1'b0;
         tail_data <= '0;
         tail_err  <= 1'b0;
         err_count <= '0;
      end else begin
         state   <= state_next;
         v_q     <= (state_next != EMPTY);
         // Also serves as the reset-done flag: rises on the first edge after release.
         ready_q <= (state_next != TWO);

         case (state)
            EMPTY: begin
               if (enq) begin
                  head_data <= dec_data;
                  head_err  <= dec_err;
               end
            end
            ONE: begin
               if (enq && !deq) begin
                  tail_data <= dec_data;
                  tail_err  <= dec_err;
               end else if (enq && deq) begin
                  head_data <= dec_data;
                  head_err  <= dec_err;
               end else if (deq) begin
                  head_data <= '0;
                  head_err  <= 1'b0;
               end
            end
            TWO: begin
               if (deq) begin
                  head_data <= tail_data;
                  head_err  <= tail_err;
                  tail_data <= '0;
                  tail_err  <= 1'b0;
               end
            end
            default: begin
               head_data <= '0;
               head_err  <= 1'b0;
            end
         endcase

         if (enq && dec_err && (err_count != {count_width_p{1'b1}})) begin
            err_count <= err_count + count_width_p'(1);
         end
      end
   end

   assign bus.ready_o     = ready_q;
   assign bus.v_o         = v_q;
   assign bus.data_o      = head_data;
   assign bus.err_o       = head_err;
   assign bus.err_count_o = err_count;
endmodule

// File: tb/tb_bsg_decode_one_hot_buffered.sv
// tb/tb_bsg_decode_one_hot_buffered.sv - bench for bsg_decode_one_hot_buffered
module tb_bsg_decode_one_hot_buffered;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   bsg_decode_one_hot_buffered_if #(.width_p(8), .count_width_p(8)) if8 ();
   bsg_decode_one_hot_buffered_if #(.width_p(6), .count_width_p(2)) if6 ();

   bsg_decode_one_hot_buffered #(.width_p(8), .count_width_p(8)) dut8 (
      .clk_i(clk), .reset_n_i(rst_n), .bus(if8.slave)
   );
   bsg_decode_one_hot_buffered #(.width_p(6), .count_width_p(2)) dut6 (
      .clk_i(clk), .reset_n_i(rst_n), .bus(if6.slave)
   );

   // Reference: a FIFO of {err, one-hot} capped at two entries.
   logic [8:0] q8[$];
   logic [6:0] q6[$];
   int         cnt8, cnt6;
   bit         rdy8, rdy6;

   function automatic logic [8:0] ref8(int a);
      return (a < 8) ? {1'b0, 8'(1 << a)} : {1'b1, 8'h00};
   endfunction

   function automatic logic [6:0] ref6(int a);
      return (a < 6) ? {1'b0, 6'(1 << a)} : {1'b1, 6'h00};
   endfunction

   function automatic int enc8(logic [7:0] v);
      int r = -1;
      for (int k = 0; k < 8; k++) if (v == 8'(1 << k)) r = k;
      return r;
   endfunction

   function automatic logic [8:0] head8();
      return (q8.size() > 0) ? q8[0] : 9'h0;
   endfunction

   function automatic logic [6:0] head6();
      return (q6.size() > 0) ? q6[0] : 7'h0;
   endfunction

   task automatic model_clear();
      q8.delete(); q6.delete();
      cnt8 = 0; cnt6 = 0; rdy8 = 0; rdy6 = 0;
   endtask

   task automatic idle();
      if8.v_i = 0; if8.addr_i = '0; if8.yumi_i = 0;
      if6.v_i = 0; if6.addr_i = '0; if6.yumi_i = 0;
   endtask

   task automatic tick();
      bit e, d;
      @(posedge clk);
      if (!rst_n) begin
         model_clear();
      end else begin
         e = if8.v_i && rdy8; d = (q8.size() > 0) && if8.yumi_i;
         if (d) void'(q8.pop_front());
         if (e) begin
            q8.push_back(ref8(int'(if8.addr_i)));
            if (int'(if8.addr_i) >= 8 && cnt8 < 255) cnt8++;
         end
         rdy8 = q8.size() < 2;
         e = if6.v_i && rdy6; d = (q6.size() > 0) && if6.yumi_i;
         if (d) void'(q6.pop_front());
         if (e) begin
            q6.push_back(ref6(int'(if6.addr_i)));
            if (int'(if6.addr_i) >= 6 && cnt6 < 3) cnt6++;
         end
         rdy6 = q6.size() < 2;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle();
      model_clear();
      if8.v_i = 1; if6.v_i = 1; if6.addr_i = 3'd7;
      tick(); tick();
      total++; if (if8.v_o !== 1'b0) begin bad++; $display("FAIL reset_v8 got %b want 0", if8.v_o); end
      total++; if (if8.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready8 got %b want 0", if8.ready_o); end
      total++; if (if8.err_count_o !== 8'd0) begin bad++; $display("FAIL reset_cnt8 got %0d want 0", if8.err_count_o); end
      total++; if (if6.v_o !== 1'b0) begin bad++; $display("FAIL reset_v6 got %b want 0", if6.v_o); end
      total++; if (if6.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready6 got %b want 0", if6.ready_o); end
      total++; if (if6.err_count_o !== 2'd0) begin bad++; $display("FAIL reset_cnt6 got %0d want 0", if6.err_count_o); end
      rst_n = 1;
      tick();
      total++; if (if8.ready_o !== 1'b1) begin bad++; $display("FAIL release_ready8 got %b want 1", if8.ready_o); end
      total++; if (if6.ready_o !== 1'b1) begin bad++; $display("FAIL release_ready6 got %b want 1", if6.ready_o); end
      total++; if (if8.v_o !== 1'b0) begin bad++; $display("FAIL release_v8 got %b want 0", if8.v_o); end
      idle();
   endtask

   task automatic test_stream();
      idle();
      if8.yumi_i = 1;
      for (int i = 0; i < 8; i++) begin
         if8.v_i = 1; if8.addr_i = 3'(i);
         tick();
         total++; if (if8.v_o !== 1'b1 || if8.data_o !== 8'(1 << i) || if8.err_o !== 1'b0)
            begin bad++; $display("FAIL stream_%0d got v=%b d=%h e=%b want v=1 d=%h e=0", i, if8.v_o, if8.data_o, if8.err_o, 8'(1 << i)); end
         total++; if (enc8(if8.data_o) !== i)
            begin bad++; $display("FAIL stream_enc_%0d got %0d want %0d", i, enc8(if8.data_o), i); end
      end
      if8.v_i = 0;
      tick();
      total++; if (if8.v_o !== 1'b0) begin bad++; $display("FAIL stream_drain got v=%b want 0", if8.v_o); end
      idle();
   endtask

   task automatic test_backpressure();
      idle();
      if8.v_i = 1; if8.addr_i = 3'd3; tick();
      if8.addr_i = 3'd5; tick();
      total++; if (if8.ready_o !== 1'b0 || if8.data_o !== 8'h08)
         begin bad++; $display("FAIL bp_full got r=%b d=%h want r=0 d=08", if8.ready_o, if8.data_o); end
      if8.addr_i = 3'd6; tick();
      total++; if (if8.ready_o !== 1'b0 || if8.data_o !== 8'h08)
         begin bad++; $display("FAIL bp_hold got r=%b d=%h want r=0 d=08", if8.ready_o, if8.data_o); end
      if8.yumi_i = 1; tick();
      total++; if (if8.ready_o !== 1'b1 || if8.data_o !== 8'h20)
         begin bad++; $display("FAIL bp_pop got r=%b d=%h want r=1 d=20", if8.ready_o, if8.data_o); end
      if8.yumi_i = 0; tick();
      total++; if (if8.ready_o !== 1'b0 || if8.data_o !== 8'h20)
         begin bad++; $display("FAIL bp_accept6 got r=%b d=%h want r=0 d=20", if8.ready_o, if8.data_o); end
      if8.v_i = 0; if8.yumi_i = 1; tick();
      total++; if (if8.v_o !== 1'b1 || if8.data_o !== 8'h40)
         begin bad++; $display("FAIL bp_last got v=%b d=%h want v=1 d=40", if8.v_o, if8.data_o); end
      tick();
      total++; if (if8.v_o !== 1'b0 || if8.data_o !== 8'h00)
         begin bad++; $display("FAIL bp_empty got v=%b d=%h want v=0 d=00", if8.v_o, if8.data_o); end
      idle();
   endtask

   task automatic test_out_of_range();
      int a[3]   = '{5, 6, 7};
      int ed[3]  = '{32, 0, 0};
      int ee[3]  = '{0, 1, 1};
      int ec[3]  = '{0, 1, 2};
      idle();
      if6.yumi_i = 1;
      for (int i = 0; i < 3; i++) begin
         if6.v_i = 1; if6.addr_i = 3'(a[i]);
         tick();
         total++; if (if6.data_o !== 6'(ed[i]) || if6.err_o !== 1'(ee[i]) || if6.err_count_o !== 2'(ec[i]))
            begin bad++; $display("FAIL oor_%0d got d=%h e=%b c=%0d want d=%h e=%0d c=%0d", a[i], if6.data_o, if6.err_o, if6.err_count_o, 6'(ed[i]), ee[i], ec[i]); end
      end
      if6.v_i = 0; tick();
      total++; if (if6.v_o !== 1'b0 || if6.err_o !== 1'b0 || if6.err_count_o !== 2'd2)
         begin bad++; $display("FAIL oor_drain got v=%b e=%b c=%0d want v=0 e=0 c=2", if6.v_o, if6.err_o, if6.err_count_o); end
      idle();
   endtask

   task automatic test_saturation();
      int ec[5] = '{1, 2, 3, 3, 3};
      idle();
      #2 rst_n = 0;
      model_clear();
      #1 rst_n = 1;
      tick();
      if6.yumi_i = 1;
      for (int i = 0; i < 5; i++) begin
         if6.v_i = 1; if6.addr_i = (i % 2 == 0) ? 3'd6 : 3'd7;
         tick();
         total++; if (if6.err_count_o !== 2'(ec[i]))
            begin bad++; $display("FAIL sat_%0d got %0d want %0d", i, if6.err_count_o, ec[i]); end
      end
      idle(); tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         if8.v_i = 1'($urandom); if8.addr_i = 3'($urandom_range(0, 7)); if8.yumi_i = 1'($urandom);
         if6.v_i = 1'($urandom); if6.addr_i = 3'($urandom_range(0, 7)); if6.yumi_i = 1'($urandom);
         tick();
         total++; if ({if8.v_o, if8.ready_o, if8.err_o, if8.data_o, if8.err_count_o} !==
                      {q8.size() > 0, rdy8, head8(), 8'(cnt8)})
            begin bad++; $display("FAIL rand8_%0d got v=%b r=%b e=%b d=%h c=%0d want v=%b r=%b h=%h c=%0d", n,
               if8.v_o, if8.ready_o, if8.err_o, if8.data_o, if8.err_count_o, q8.size() > 0, rdy8, head8(), cnt8); end
         total++; if ({if6.v_o, if6.ready_o, if6.err_o, if6.data_o, if6.err_count_o} !==
                      {q6.size() > 0, rdy6, head6(), 2'(cnt6)})
            begin bad++; $display("FAIL rand6_%0d got v=%b r=%b e=%b d=%h c=%0d want v=%b r=%b h=%h c=%0d", n,
               if6.v_o, if6.ready_o, if6.err_o, if6.data_o, if6.err_count_o, q6.size() > 0, rdy6, head6(), cnt6); end
      end
      idle();
   endtask

   task automatic test_midreset();
      idle();
      if8.v_i = 1; if8.addr_i = 3'd1;
      if6.v_i = 1; if6.addr_i = 3'd7;
      tick(); tick();
      total++; if (if8.ready_o !== 1'b0 || if8.v_o !== 1'b1 || if6.ready_o !== 1'b0)
         begin bad++; $display("FAIL mid_full got r8=%b v8=%b r6=%b want 0 1 0", if8.ready_o, if8.v_o, if6.ready_o); end
      #2 rst_n = 0;
      #1;
      total++; if (if8.v_o !== 1'b0 || if8.data_o !== 8'h00 || if8.ready_o !== 1'b0)
         begin bad++; $display("FAIL mid_async8 got v=%b d=%h r=%b want 0 00 0", if8.v_o, if8.data_o, if8.ready_o); end
      total++; if (if6.v_o !== 1'b0 || if6.err_o !== 1'b0 || if6.err_count_o !== 2'd0)
         begin bad++; $display("FAIL mid_async6 got v=%b e=%b c=%0d want 0 0 0", if6.v_o, if6.err_o, if6.err_count_o); end
      model_clear();
      tick();
      rst_n = 1;
      idle();
      if8.yumi_i = 1; if6.yumi_i = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (if8.v_o !== 1'b0 || if6.v_o !== 1'b0)
            begin bad++; $display("FAIL mid_stale_%0d got v8=%b v6=%b want 0 0", i, if8.v_o, if6.v_o); end
      end
      idle();
   endtask

   initial begin
      idle();
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_out_of_range();
      test_saturation();
      test_random();
      test_midreset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
